muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Parametrised multi-cycle multiply/divide unit for the mini-MIPS datapath, accepting the R-type mult/multu/div/divu function codes.
- Runs an iterative shift-add multiply or restoring divide over WIDTH cycles.
- Holds the result in HI/LO registers.
- Serves mfhi/mflo reads through a result mux.
- Sits beside the ALU. The controller stalls on busy and writes back on mfhi/mflo.

Parameters:
WIDTH, 8, operand and HI/LO register width in bits (>=4)
CW, $clog2(WIDTH+1), iteration counter width (derived; do not override)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
aluop  input  2  ALU op class from controller; 2'b10 = R-type
funct  input  6  instruction funct field
a  input  WIDTH  operand rs (multiplicand / dividend)
b  input  WIDTH  operand rt (multiplier / divisor)
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse when HI/LO have been updated
dz  output  1  divide-by-zero flag, valid with done, held until next accepted start
hi  output  WIDTH  HI register (product upper half / remainder)
lo  output  WIDTH  LO register (product lower half / quotient)
result  output  WIDTH  combinational: hi if funct=010000 (mfhi), lo if funct=010010 (mflo), else 0; forced to 0 unless aluop=2'b10

Behaviour:
- Recognised ops, only when aluop=2'b10:
  - mult 011000: signed multiply
  - multu 011001: unsigned multiply
  - div 011010: signed divide
  - divu 011011: unsigned divide
- Any other aluop/funct combined with start is ignored: no state change, busy stays 0.
- Reset (async, any state, including mid-operation):
  - state=IDLE, counter=0
  - hi=0, lo=0, busy=0, done=0, dz=0
  - working registers cleared; any in-flight operation is abandoned and produces no done.
- States:
  - IDLE -> CALC on an accepted start. Operands are latched at that edge (edge E0). Signed ops latch magnitudes and record the result sign(s).
  - CALC: one iteration per edge for WIDTH edges (E1..E_WIDTH), then -> FIX.
  - FIX: at edge E_WIDTH+1, apply sign correction, write hi/lo, set done=1, then -> IDLE.
- Timing:
  - busy = (state != IDLE): high from after E0 until after E_WIDTH+1.
  - done is high for exactly the one cycle following E_WIDTH+1.
  - Total latency is WIDTH+2 edges including the start edge.
  - A new start is accepted in the cycle done is high, since the state is already IDLE.
- start while busy is ignored; the operands/funct of the running op are unaffected.
- Multiply: 2*WIDTH-bit product; hi = upper WIDTH bits, lo = lower WIDTH bits. Signed result is the two's-complement 2*WIDTH-bit product.
- Divide: restoring, one quotient bit per iteration; lo = quotient, hi = remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Overflow case -2^(WIDTH-1) / -1: lo = -2^(WIDTH-1) (bit pattern 100..0), hi = 0, dz = 0.
- Divide by zero (b=0, div or divu): full latency still runs; lo = all ones, hi = a (as latched); dz=1 with done.
- dz is cleared on the next accepted start.
- hi/lo change only at the FIX edge or on reset, so mfhi/mflo reads during busy return the previous result.
- No arithmetic wraps silently except as defined above; all internal widths are WIDTH or 2*WIDTH.

Test Plan:
- WIDTH=8, reset, then multu a=200 b=3 (start at E0) -> busy 1 for E0..E9, done pulse after E9; hi=0x02, lo=0x58, dz=0; mflo result=0x58.
- mult a=0xFD(-3) b=0x05 -> hi=0xFF, lo=0xF1. Then div a=0xF9(-7) b=0x02 -> lo=0xFD(-3), hi=0xFF(-1).
- divu a=7 b=0 -> after 10 edges lo=0xFF, hi=0x07, dz=1. Next accepted start -> dz=0 at that edge.
- div a=0x80 b=0xFF -> lo=0x80, hi=0x00, dz=0. Also check a=0x80 b=0x01 -> lo=0x80, hi=0x00.
- Issue multu 5*6; assert start with divu 9/3 at E3 -> ignored, result hi=0x00 lo=0x1E. Start with funct=100000 (add) in IDLE -> busy stays 0, no done.
- Reset asserted asynchronously at E4 of a mult -> busy, done, hi, lo drop to 0 immediately. No done after release. A fresh multu 2*2 -> lo=0x04 after full latency.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit for the mini-MIPS datapath.
//
// Executes mult/multu (iterative shift-add) and div/divu (restoring divide)
// over WIDTH iteration cycles, then applies sign correction and writes the
// HI/LO registers. mfhi/mflo reads are served combinationally on 'result'.
//
// Ports:
//   clk    - system clock, rising-edge
//   reset  - asynchronous, active-high reset
//   start  - operation request, sampled only while idle
//   aluop  - ALU op class from controller (2'b10 = R-type)
//   funct  - instruction funct field
//   a, b   - operands rs / rt
//   busy   - high while an operation is in flight
//   done   - one-cycle pulse after HI/LO are written
//   dz     - divide-by-zero flag, valid with done, held until next start
//   hi, lo - HI/LO result registers
//   result - mfhi/mflo read mux output (0 for any other instruction)
module muldiv_unit #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MFLO = 6'b010010;

  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_res;   // sign of product / quotient
  logic               neg_rem;   // sign of remainder (dividend sign)
  logic               divzero;
  logic [WIDTH-1:0]   opb;       // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   a_raw;     // dividend as latched, for divide-by-zero
  logic [2*WIDTH-1:0] acc;       // {upper, lower} working register

  // Operation decode: funct 0110xx covers mult, multu, div, divu.
  logic accept;
  logic op_signed;
  logic a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign accept    = start && (state == S_IDLE) && (aluop == 2'b10) &&
                     (funct[5:2] == 4'b0110);
  assign op_signed = ~funct[0];
  assign a_neg     = op_signed & a[WIDTH-1];
  assign b_neg     = op_signed & b[WIDTH-1];
  assign a_mag     = a_neg ? (~a + 1'b1) : a;
  assign b_mag     = b_neg ? (~b + 1'b1) : b;

  // One shift-add multiply step: conditionally add the multiplicand to the
  // upper half (keeping the carry), then shift the whole register right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  // One restoring-divide step: shift the next dividend bit into the partial
  // remainder and try to subtract the divisor; the extra top bit is the borrow.
  logic [WIDTH+1:0]   div_trial;
  logic [2*WIDTH-1:0] div_next;

  // Sign-corrected results applied at the FIX edge.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    mul_sum   = '0;
    mul_next  = '0;
    div_trial = '0;
    div_next  = '0;
    prod_fix  = '0;
    quo_fix   = '0;
    rem_fix   = '0;

    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};

    div_trial = {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {2'b00, opb};
    if (div_trial[WIDTH+1])
      div_next = {acc[2*WIDTH-2:0], 1'b0};
    else
      div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    prod_fix = neg_res ? (~acc + 1'b1) : acc;
    quo_fix  = neg_res ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: working registers are reset too, so an abandoned operation
      // leaves no stale state behind for the next one.
      state   <= S_IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      divzero <= 1'b0;
      opb     <= '0;
      a_raw   <= '0;
      acc     <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      dz      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state   <= S_CALC;
            cnt     <= '0;
            is_div  <= funct[1];
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            divzero <= funct[1] && (b == '0);
            a_raw   <= a;
            dz      <= 1'b0;
            if (funct[1]) begin
              acc <= {{WIDTH{1'b0}}, a_mag};
              opb <= b_mag;
            end else begin
              acc <= {{WIDTH{1'b0}}, b_mag};
              opb <= a_mag;
            end
          end
        end
        S_CALC: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ITER)
            state <= S_FIX;
        end
        S_FIX: begin
          state <= S_IDLE;
          done  <= 1'b1;
          dz    <= divzero;
          if (!is_div) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (divzero) begin
            hi <= a_raw;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

  always_comb begin
    result = '0;
    if (aluop == 2'b10) begin
      if (funct == F_MFHI)
        result = hi;
      else if (funct == F_MFLO)
        result = lo;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit (WIDTH=8).
// Expected HI/LO/dz are computed by a reference model when an operation is
// issued, pushed to a scoreboard queue, and compared when done pulses.
module tb_muldiv_unit;

  localparam int W = 8;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   aluop;
  logic [5:0]   funct;
  logic [W-1:0] a, b;
  logic         busy, done, dz;
  logic [W-1:0] hi, lo, result;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .aluop  (aluop),
    .funct  (funct),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .dz     (dz),
    .hi     (hi),
    .lo     (lo),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model using the simulator's own integer arithmetic.
  function automatic exp_t model(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   e;
    longint sx, sy, p, q, r;
    sx = f[0] ? longint'(x) : longint'($signed(x));
    sy = f[0] ? longint'(y) : longint'($signed(y));
    e.dz = 1'b0;
    if (!f[1]) begin
      p    = sx * sy;
      e.hi = p[2*W-1:W];
      e.lo = p[W-1:0];
    end else if (y == '0) begin
      e.hi = x;
      e.lo = '1;
      e.dz = 1'b1;
    end else begin
      q    = sx / sy;
      r    = sx % sy;
      e.hi = r[W-1:0];
      e.lo = q[W-1:0];
    end
    return e;
  endfunction

  // Scoreboard consumer: every done pulse pops one expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexp_done", done, 0);
      end else begin
        e = sbq.pop_front();
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
        check("dz", dz, e.dz);
      end
    end
  end

  // Drive a request for the E0 edge; returns at the negedge after E0.
  task automatic start_op(input logic [5:0] f, input logic [W-1:0] x,
                          input logic [W-1:0] y, input bit expect_done);
    @(negedge clk);
    aluop = 2'b10;
    funct = f;
    a     = x;
    b     = y;
    start = 1'b1;
    if (expect_done) sbq.push_back(model(f, x, y));
    @(negedge clk);
    start = 1'b0;
    check("busy_e0", busy, 1);
  endtask

  // Wait (bounded) for done; cyc counts negedges since E0.
  task automatic wait_done(input int cyc0);
    int cyc = cyc0;
    while (done !== 1'b1 && cyc < W + 6) begin
      check("busy_hold", busy, 1);
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, W + 1);
    check("busy_done", busy, 0);
  endtask

  task automatic do_op(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    start_op(f, x, y, 1'b1);
    wait_done(0);
  endtask

  task automatic read_hilo(input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    @(negedge clk);
    aluop = 2'b10;
    funct = F_MFHI;
    #1 check("mfhi", result, exp_hi);
    funct = F_MFLO;
    #1 check("mflo", result, exp_lo);
  endtask

  initial begin : timeout
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    aluop = 2'b00;
    funct = '0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz",   dz,   0);
    check("rst_hi",   hi,   0);
    check("rst_lo",   lo,   0);

    // Unsigned multiply and result mux.
    do_op(F_MULTU, 8'd200, 8'd3);
    read_hilo(8'h02, 8'h58);
    aluop = 2'b00;
    #1 check("mux_not_rtype", result, 0);
    aluop = 2'b10;
    funct = F_ADD;
    #1 check("mux_other_funct", result, 0);

    // Signed multiply and signed divide.
    do_op(F_MULT, 8'hFD, 8'h05);
    do_op(F_DIV,  8'hF9, 8'h02);

    // Divide by zero; dz held, then cleared on next accepted start.
    do_op(F_DIVU, 8'd7, 8'd0);
    repeat (3) @(negedge clk);
    check("dz_held", dz, 1);
    start_op(F_DIVU, 8'd100, 8'd7, 1'b1);
    check("dz_cleared", dz, 0);
    wait_done(0);

    // Signed overflow and min / 1.
    do_op(F_DIV, 8'h80, 8'hFF);
    do_op(F_DIV, 8'h80, 8'h01);

    // start while busy is ignored.
    start_op(F_MULTU, 8'd5, 8'd6, 1'b1);
    repeat (2) @(negedge clk);
    funct = F_DIVU;
    a     = 8'd9;
    b     = 8'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(3);
    check("ign_hi", hi, 8'h00);
    check("ign_lo", lo, 8'h1E);

    // Unrecognised funct in IDLE is ignored.
    @(negedge clk);
    aluop = 2'b10;
    funct = F_ADD;
    a     = 8'd1;
    b     = 8'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("add_busy", busy, 0);
    repeat (W + 3) @(negedge clk);
    check("add_lo_kept", lo, 8'h1E);

    // Asynchronous reset in mid-operation.
    start_op(F_MULT, 8'h13, 8'h07, 1'b0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_hi",   hi,   0);
    check("arst_lo",   lo,   0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      check("no_done_after_rst", done, 0);
    end
    do_op(F_MULTU, 8'd2, 8'd2);
    check("post_rst_lo", lo, 8'h04);

    // Randomised ops across all four functions (divisor may be zero).
    for (int i = 0; i < 12; i++) begin
      logic [5:0] f;
      f = F_MULT + 6'($urandom_range(0, 3));
      do_op(f, W'($urandom), W'($urandom_range(0, 3) == 0 ? 0 : $urandom));
    end

    repeat (3) @(negedge clk);
    check("sb_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
